mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 4: consecutive data grants allowed while a fetch waits.
REQ-002 Parameter ADDR_W, default 8: byte-address width of the unified memory.
REQ-003 sclk  in  1  the block's only clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch stage requests an instruction word.
REQ-006 if_addr  in  ADDR_W  fetch byte address.
REQ-007 if_gnt  out  1  fetch accepted this cycle (combinational).
REQ-008 if_stall  out  1  equals if_req AND NOT if_gnt.
REQ-009 if_rvalid  out  1  registered pulse; if_rdata is valid.
REQ-010 if_rdata  out  32  fetched instruction, held until the next fetch response.
REQ-011 d_req  in  1  memory stage requests a load or store.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data byte address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_funct3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-016 d_gnt  out  1  data request accepted this cycle (combinational).
REQ-017 d_rvalid  out  1  registered pulse; response for the accepted data request.
REQ-018 d_rdata  out  32  load result, 0 for stores and errors.
REQ-019 d_err  out  1  qualifies d_rvalid; access was misaligned or had an illegal funct3.
REQ-020 m_addr, m_write_data, m_mem_write, m_MemRead, m_inst  out  ADDR_W/32/1/1/3  drive the unified memory port.
REQ-021 m_read_data  in  32  combinational read data from the memory.

Function
REQ-022 The block shall grant at most one requester per cycle; d_req has priority unless the streak counter equals MAX_DATA_STREAK and if_req is high, in which case fetch shall win.
REQ-023 The streak counter shall increment on each data grant made while if_req is high, and shall clear on a fetch grant or whenever if_req is low.
REQ-024 On a fetch grant: m_addr = if_addr; m_MemRead = 0; m_mem_write = 0.
REQ-025 On a data load grant: m_addr = d_addr; m_MemRead = 1; m_inst = d_funct3.
REQ-026 On a data store grant: m_mem_write = 1; m_write_data = d_wdata; m_inst = d_funct3.
REQ-027 Alignment rules: h/hu accesses require d_addr[0] = 0; w accesses require d_addr[1:0] = 00.
REQ-028 Illegal funct3: loads other than 000/001/010/100/101, or stores other than 000/001/010.
REQ-029 A misaligned or illegal-funct3 data access shall be granted and counted, but m_mem_write and m_MemRead shall stay 0; the next cycle shall give d_rvalid = 1, d_err = 1, d_rdata = 0.
REQ-030 Responses shall arrive 1 cycle after the grant: m_read_data is registered into if_rdata or d_rdata, together with the matching rvalid pulse; stores return d_rvalid with d_rdata = 0.
REQ-031 With no grant: m_mem_write = 0, m_MemRead = 0, m_addr = 0, and no rvalid follows.
REQ-032 Address arithmetic shall not wrap; any access whose last byte exceeds 2^ADDR_W-1 is misaligned by REQ-027.

Reset
REQ-033 While rst = 0: streak counter = 0; if_rvalid = d_rvalid = d_err = 0; d_rdata = 0; if_rdata = 32'h00000013 (NOP).
REQ-034 Asserting rst discards any response in flight; after rst is released, outputs shall be as in REQ-033 until the first new grant.
REQ-035 Request inputs shall be ignored while rst = 0.

Structure
REQ-036 The funct3 encodings, the NOP constant and the MAX_DATA_STREAK default shall live in shared package mem_arb_pkg.
REQ-037 The priority/streak logic shall be sub-module arb_streak_ctr; alignment checks and response registers shall stay in the top.

Verification
REQ-038 Fetch only, if_addr = 0x04 with memory word 0x0800_0F93 -> if_gnt same cycle; if_rvalid and if_rdata = 0x0800_0F93 next cycle.
REQ-039 Both request every cycle with MAX_DATA_STREAK = 4 -> grant pattern D,D,D,D,F repeating; if_stall high during the D cycles.
REQ-040 Store sw 0x1234_5678 to 0x80, then lw from 0x80 -> m_mem_write pulse on the store grant; load d_rdata = 0x1234_5678.
REQ-041 lh at 0x81 and sw funct3 = 100 -> no memory strobe; d_rvalid = 1, d_err = 1, d_rdata = 0.
REQ-042 lb at 0x80 with byte 0xF1, then lbu at 0x80 -> d_rdata = 0xFFFF_FFF1, then 0x0000_00F1.
REQ-043 rst asserted the cycle after a load grant -> no d_rvalid; if_rdata = 0x0000_0013; streak counter = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: access encodings,
// reset instruction and the data-streak limit.
package mem_arb_pkg;

    localparam int unsigned MAX_DATA_STREAK_DEFAULT = 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Stores only accept signed-size encodings; loads also take the unsigned forms.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic r;
        case (f3)
            F3_B, F3_H, F3_W: r = 1'b1;
            F3_BU, F3_HU:     r = ~is_store;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lsb);
        logic r;
        case (f3[1:0])
            2'b01:   r = (lsb[0] == 1'b0);
            2'b10:   r = (lsb == 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arb_streak_ctr.sv
// Fixed-priority arbiter with a starvation guard: data wins until it has
// taken MAX_DATA_STREAK grants in a row while a fetch was waiting.
module arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEFAULT,
    localparam int unsigned CNT_W = $clog2(MAX_DATA_STREAK + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_if_req,
    input  logic             i_d_req,
    output logic             o_if_gnt,
    output logic             o_d_gnt,
    output logic [CNT_W-1:0] o_streak
);

    logic [CNT_W-1:0] r_streak;
    logic             w_at_limit;

    assign w_at_limit = (r_streak == CNT_W'(MAX_DATA_STREAK));
    assign o_if_gnt   = i_if_req & (~i_d_req | w_at_limit);
    assign o_d_gnt    = i_d_req & ~o_if_gnt;
    assign o_streak   = r_streak;

    // Only data grants that overtake a waiting fetch count toward the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_streak <= '0;
        end else if (o_if_gnt || !i_if_req) begin
            r_streak <= '0;
        end else if (o_d_gnt) begin
            r_streak <= r_streak + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one combinational memory port between instruction fetch and the
// load/store stage; responses come back one cycle after the grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEFAULT,
    parameter int unsigned ADDR_W = 8,
    localparam int unsigned CNT_W = $clog2(MAX_DATA_STREAK + 1)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_write_data,
    output logic              m_mem_write,
    output logic              m_MemRead,
    output logic [2:0]        m_inst,
    input  logic [31:0]       m_read_data,
    output logic [CNT_W-1:0]  dbg_streak
);

    logic        w_if_req;
    logic        w_d_req;
    logic        w_d_ok;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_d_rvalid;
    logic        r_d_err;
    logic [31:0] r_d_rdata;

    // Requests are masked during reset so nothing is granted or counted.
    assign w_if_req = if_req & rst;
    assign w_d_req  = d_req & rst;

    arb_streak_ctr #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_arb (
        .i_clk    (sclk),
        .i_rst_n  (rst),
        .i_if_req (w_if_req),
        .i_d_req  (w_d_req),
        .o_if_gnt (if_gnt),
        .o_d_gnt  (d_gnt),
        .o_streak (dbg_streak)
    );

    assign if_stall = w_if_req & ~if_gnt;
    assign w_d_ok   = funct3_legal(d_funct3, d_we) & addr_aligned(d_funct3, d_addr[1:0]);

    // A rejected data access is still granted, but never strobes the memory.
    always_comb begin
        m_addr       = '0;
        m_write_data = '0;
        m_mem_write  = 1'b0;
        m_MemRead    = 1'b0;
        m_inst       = F3_W;
        if (if_gnt) begin
            m_addr = if_addr;
        end else if (d_gnt) begin
            m_addr = d_addr;
            m_inst = d_funct3;
            if (w_d_ok) begin
                if (d_we) begin
                    m_mem_write  = 1'b1;
                    m_write_data = d_wdata;
                end else begin
                    m_MemRead = 1'b1;
                end
            end
        end
    end

    // Read data holds between responses; only rvalid and err are pulses.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= NOP_INSN;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= if_gnt;
            r_d_rvalid  <= d_gnt;
            r_d_err     <= d_gnt & ~w_d_ok;
            if (if_gnt) begin
                r_if_rdata <= m_read_data;
            end
            if (d_gnt) begin
                r_d_rdata <= (w_d_ok && !d_we) ? m_read_data : '0;
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed memory environment, a
// request-level reference model checked every cycle, and directed scenarios.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        sclk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, d_req, d_we;
    logic [7:0]  if_addr, d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        if_gnt, if_stall, if_rvalid, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic [7:0]  m_addr;
    logic [31:0] m_write_data, m_read_data;
    logic        m_mem_write, m_MemRead;
    logic [2:0]  m_inst;
    logic [2:0]  dbg_streak;

    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr, poke_data;
    logic [7:0]  env_mem [256];
    logic [7:0]  ref_mem [256];

    int n_checks = 0;
    int n_pass = 0;

    logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    always #5 sclk = ~sclk;

    mem_port_arbiter #(
        .MAX_DATA_STREAK(MAXS),
        .ADDR_W(8)
    ) dut (
        .sclk(sclk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_write_data(m_write_data), .m_mem_write(m_mem_write),
        .m_MemRead(m_MemRead), .m_inst(m_inst), .m_read_data(m_read_data),
        .dbg_streak(dbg_streak)
    );

    // Memory environment: combinational read formatted by m_inst.
    always_comb begin : env_rd
        logic [7:0] b0, b1, b2, b3;
        b0 = env_mem[m_addr];
        b1 = env_mem[m_addr + 8'd1];
        b2 = env_mem[m_addr + 8'd2];
        b3 = env_mem[m_addr + 8'd3];
        case (m_inst)
            3'b000:  m_read_data = {{24{b0[7]}}, b0};
            3'b001:  m_read_data = {{16{b1[7]}}, b1, b0};
            3'b100:  m_read_data = {24'h0, b0};
            3'b101:  m_read_data = {16'h0, b1, b0};
            default: m_read_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge sclk) begin
        if (poke_en) begin
            env_mem[poke_addr] <= poke_data;
        end else if (m_mem_write) begin
            env_mem[m_addr] <= m_write_data[7:0];
            if (m_inst[1:0] != 2'b00) env_mem[m_addr + 8'd1] <= m_write_data[15:8];
            if (m_inst[1:0] == 2'b10) begin
                env_mem[m_addr + 8'd2] <= m_write_data[23:16];
                env_mem[m_addr + 8'd3] <= m_write_data[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin : model
        int          streak, size, base, fa;
        logic        exp_ifg, exp_dg, acc_ok, legal, exp_ifv, exp_dv, exp_err;
        logic [31:0] word, ld, exp_if_rdata, exp_d_rdata;
        logic [33:0] item;
        logic [33:0] exp_q [$];
        streak = 0;
        exp_if_rdata = 32'h0000_0013;
        exp_d_rdata = 32'h0;
        forever begin
            @(negedge sclk);
            if (poke_en) ref_mem[poke_addr] = poke_data;
            if (!rst) begin
                exp_q.delete();
                streak = 0;
                exp_if_rdata = 32'h0000_0013;
                exp_d_rdata = 32'h0;
                check("rst_if_gnt", if_gnt, 0);
                check("rst_d_gnt", d_gnt, 0);
                check("rst_if_stall", if_stall, 0);
                check("rst_if_rvalid", if_rvalid, 0);
                check("rst_d_rvalid", d_rvalid, 0);
                check("rst_d_err", d_err, 0);
                check("rst_d_rdata", d_rdata, 0);
                check("rst_if_rdata", if_rdata, 32'h0000_0013);
                check("rst_streak", 32'(dbg_streak), 0);
                check("rst_mem_write", m_mem_write, 0);
                check("rst_memread", m_MemRead, 0);
            end else begin
                exp_ifv = 0;
                exp_dv = 0;
                exp_err = 0;
                if (exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    if (item[33]) begin
                        exp_dv = 1;
                        exp_err = item[32];
                        exp_d_rdata = item[31:0];
                    end else begin
                        exp_ifv = 1;
                        exp_if_rdata = item[31:0];
                    end
                end
                check("if_rvalid", if_rvalid, exp_ifv);
                check("if_rdata", if_rdata, exp_if_rdata);
                check("d_rvalid", d_rvalid, exp_dv);
                check("d_err", d_err, exp_err);
                check("d_rdata", d_rdata, exp_d_rdata);
                check("streak", 32'(dbg_streak), 32'(streak));

                exp_ifg = if_req && (!d_req || streak == MAXS);
                exp_dg = d_req && !exp_ifg;
                check("if_gnt", if_gnt, exp_ifg);
                check("d_gnt", d_gnt, exp_dg);
                check("if_stall", if_stall, if_req && !exp_ifg);

                case (int'(d_funct3) % 4)
                    1: size = 2;
                    2: size = 4;
                    default: size = 1;
                endcase
                legal = d_we ? (d_funct3 inside {3'd0, 3'd1, 3'd2})
                             : (d_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                acc_ok = legal && (int'(d_addr) % size == 0);

                if (exp_ifg) begin
                    fa = int'(if_addr);
                    word = {ref_mem[(fa + 3) % 256], ref_mem[(fa + 2) % 256],
                            ref_mem[(fa + 1) % 256], ref_mem[fa]};
                    check("f_m_addr", 32'(m_addr), 32'(if_addr));
                    check("f_memread", m_MemRead, 0);
                    check("f_mem_write", m_mem_write, 0);
                    exp_q.push_back({2'b00, word});
                end else if (exp_dg) begin
                    ld = 32'h0;
                    if (acc_ok) begin
                        check("d_m_addr", 32'(m_addr), 32'(d_addr));
                        check("d_m_inst", 32'(m_inst), 32'(d_funct3));
                        check("d_memread", m_MemRead, !d_we);
                        check("d_mem_write", m_mem_write, d_we);
                        if (d_we) begin
                            check("d_m_wdata", m_write_data, d_wdata);
                            for (int k = 0; k < size; k++)
                                ref_mem[(int'(d_addr) + k) % 256] = 8'(d_wdata >> (8 * k));
                        end else begin
                            base = int'(d_addr) - int'(d_addr) % 4;
                            word = {ref_mem[base + 3], ref_mem[base + 2],
                                    ref_mem[base + 1], ref_mem[base]};
                            word = word >> (8 * (int'(d_addr) % 4));
                            if (size == 1) begin
                                ld = word & 32'hFF;
                                if (d_funct3 == 3'd0 && ld >= 128) ld = ld - 32'd256;
                            end else if (size == 2) begin
                                ld = word & 32'hFFFF;
                                if (d_funct3 == 3'd1 && ld >= 32768) ld = ld - 32'd65536;
                            end else begin
                                ld = word;
                            end
                        end
                    end else begin
                        check("err_memread", m_MemRead, 0);
                        check("err_mem_write", m_mem_write, 0);
                    end
                    exp_q.push_back({1'b1, !acc_ok, ld});
                end else begin
                    check("idle_m_addr", 32'(m_addr), 0);
                    check("idle_memread", m_MemRead, 0);
                    check("idle_mem_write", m_mem_write, 0);
                end

                if (exp_ifg || !if_req) streak = 0;
                else if (exp_dg) streak++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge sclk);
        #1;
    endtask

    task automatic set_idle();
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        poke_en = 1; poke_addr = a; poke_data = v;
        next_cycle();
        poke_en = 0;
    endtask

    task automatic data_req(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
        d_req = 1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    endtask

    initial begin : stim
        int s;
        set_idle();
        rst = 0;
        next_cycle();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
        @(negedge sclk);
        check("reset_nop", if_rdata, 32'h0000_0013);
        next_cycle();
        rst = 1;
        poke(8'h04, 8'h93); poke(8'h05, 8'h0F); poke(8'h06, 8'h00); poke(8'h07, 8'h08);

        // Single fetch
        if_req = 1; if_addr = 8'h04;
        @(negedge sclk);
        check("fetch_gnt", if_gnt, 1);
        next_cycle();
        set_idle();
        @(negedge sclk);
        check("fetch_rvalid", if_rvalid, 1);
        check("fetch_rdata", if_rdata, 32'h0800_0F93);
        next_cycle();

        // Contention pattern D,D,D,D,F
        for (int i = 0; i < 10; i++) begin
            if_req = 1; if_addr = 8'h40;
            data_req(0, 3'b010, 8'h40, 0);
            @(negedge sclk);
            check("pat_d_gnt", d_gnt, (i % 5) != 4);
            check("pat_if_gnt", if_gnt, (i % 5) == 4);
            check("pat_stall", if_stall, (i % 5) != 4);
            next_cycle();
        end
        set_idle();
        next_cycle();

        // sw then lw
        data_req(1, 3'b010, 8'h80, 32'h1234_5678);
        @(negedge sclk);
        check("sw_strobe", m_mem_write, 1);
        next_cycle();
        data_req(0, 3'b010, 8'h80, 0);
        @(negedge sclk);
        check("lw_no_write", m_mem_write, 0);
        check("lw_memread", m_MemRead, 1);
        next_cycle();
        set_idle();
        @(negedge sclk);
        check("lw_rvalid", d_rvalid, 1);
        check("lw_rdata", d_rdata, 32'h1234_5678);
        next_cycle();

        // Misaligned lh, illegal store funct3
        data_req(0, 3'b001, 8'h81, 0);
        @(negedge sclk);
        check("lh_mis_read", m_MemRead, 0);
        check("lh_mis_write", m_mem_write, 0);
        next_cycle();
        data_req(1, 3'b100, 8'h84, 32'hDEAD_BEEF);
        @(negedge sclk);
        check("lh_mis_err", d_err, 1);
        check("lh_mis_rdata", d_rdata, 0);
        check("sw100_write", m_mem_write, 0);
        next_cycle();
        set_idle();
        @(negedge sclk);
        check("sw100_rvalid", d_rvalid, 1);
        check("sw100_err", d_err, 1);
        check("sw100_rdata", d_rdata, 0);
        next_cycle();

        // lb / lbu sign handling
        poke(8'h80, 8'hF1);
        data_req(0, 3'b000, 8'h80, 0);
        next_cycle();
        data_req(0, 3'b100, 8'h80, 0);
        @(negedge sclk);
        check("lb_rdata", d_rdata, 32'hFFFF_FFF1);
        next_cycle();
        set_idle();
        @(negedge sclk);
        check("lbu_rdata", d_rdata, 32'h0000_00F1);
        next_cycle();

        // Reset right after a load grant
        if_req = 1; if_addr = 8'h10;
        data_req(0, 3'b010, 8'h80, 0);
        next_cycle();
        rst = 0;
        @(negedge sclk);
        check("rst_drop_rvalid", d_rvalid, 0);
        check("rst_drop_ifrdata", if_rdata, 32'h0000_0013);
        check("rst_drop_streak", 32'(dbg_streak), 0);
        next_cycle();
        rst = 1;
        set_idle();
        @(negedge sclk);
        check("post_rst_rvalid", d_rvalid, 0);
        check("post_rst_ifrdata", if_rdata, 32'h0000_0013);
        next_cycle();

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            if_req = ($urandom_range(0, 3) != 0);
            if_addr = 8'($urandom_range(0, 63) * 4);
            d_req = ($urandom_range(0, 2) != 0);
            d_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) d_funct3 = 3'($urandom_range(0, 7));
            else d_funct3 = legal_f3[$urandom_range(0, 4)];
            s = (d_funct3[1:0] == 2'b01) ? 2 : (d_funct3[1:0] == 2'b10) ? 4 : 1;
            d_addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) d_addr = 8'(int'(d_addr) / s * s);
            d_wdata = $urandom;
            next_cycle();
        end

        rst = 1;
        set_idle();
        repeat (3) next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
